// File: rtl/fp_multiplier_seq_if.sv
// Operand/result handshake bundle for the sequential FP multiplier.
// The master side drives operands and accepts results; the slave side is the multiplier.
interface fp_multiplier_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_operand;
  logic [W-1:0] b_operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         exception;
  logic         overflow;
  logic         underflow;
  logic         inexact;

  modport master (
    output in_valid, a_operand, b_operand, out_ready,
    input  in_ready, out_valid, result, exception, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, a_operand, b_operand, out_ready,
    output in_ready, out_valid, result, exception, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_multiplier_seq.sv
// Multi-cycle IEEE-754 multiplier: shift-add significand product, RNE rounding,
// flush-to-zero for subnormals, specials resolved at acceptance.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | one multiplier bit per cycle, LSB first
// NORM  | normalise, round, range-check exponent
// DONE  | result and flags held until out_ready
module fp_multiplier_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               reset,
  fp_multiplier_seq_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(SW);
  localparam logic [EW-1:0]   BIAS_E = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-2:0]   EMAX   = (EW-1)'((1 << EXP_W) - 1);
  localparam logic [W-1:0]    QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t           state;
  logic             sign_r;
  logic [EXP_W-1:0] ea_r, eb_r;
  logic [PW-1:0]    mcand_r;
  logic [SW-1:0]    mplier_r;
  logic [PW-1:0]    acc_r;
  logic [CW-1:0]    cnt;
  logic             out_valid_r;
  logic [W-1:0]     result_r;
  logic             exception_r, overflow_r, underflow_r, inexact_r;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             s_in, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_exp  = bus.a_operand[W-2 -: EXP_W];
  assign b_exp  = bus.b_operand[W-2 -: EXP_W];
  assign a_man  = bus.a_operand[MAN_W-1:0];
  assign b_man  = bus.b_operand[MAN_W-1:0];
  assign s_in   = bus.a_operand[W-1] ^ bus.b_operand[W-1];
  assign a_nan  = (&a_exp) && (|a_man);
  assign b_nan  = (&b_exp) && (|b_man);
  assign a_inf  = (&a_exp) && !(|a_man);
  assign b_inf  = (&b_exp) && !(|b_man);
  // Subnormals carry no hidden bit here, so they are handled as signed zeros.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);

  logic             norm, guard_b, sticky_b, round_up, n_ovf, n_unf;
  logic [PW-1:0]    prod_n;
  logic [MAN_W-1:0] man_raw;
  logic [MAN_W:0]   man_sum;
  logic [EW-1:0]    e_pre, e_fin;

  always_comb begin
    norm     = acc_r[PW-1];
    prod_n   = norm ? acc_r : (acc_r << 1);
    man_raw  = prod_n[PW-2 -: MAN_W];
    guard_b  = prod_n[PW-2-MAN_W];
    sticky_b = |prod_n[PW-3-MAN_W:0];
    round_up = guard_b & (sticky_b | man_raw[0]);
    man_sum  = {1'b0, man_raw} + {{MAN_W{1'b0}}, round_up};
    // Two's complement in EXP_W+2 bits; the MSB marks a negative exponent.
    e_pre    = {2'b00, ea_r} + {2'b00, eb_r} - BIAS_E + {{(EW-1){1'b0}}, norm};
    e_fin    = e_pre + {{(EW-1){1'b0}}, man_sum[MAN_W]};
    n_ovf    = !e_fin[EW-1] && (e_fin[EW-2:0] >= EMAX);
    n_unf    = e_fin[EW-1] || (e_fin == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sign_r      <= 1'b0;
      ea_r        <= '0;
      eb_r        <= '0;
      mcand_r     <= '0;
      mplier_r    <= '0;
      acc_r       <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      exception_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      inexact_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign_r      <= s_in;
          ea_r        <= a_exp;
          eb_r        <= b_exp;
          mcand_r     <= {{SW{1'b0}}, 1'b1, a_man};
          mplier_r    <= {1'b1, b_man};
          acc_r       <= '0;
          cnt         <= CW'(MAN_W);
          exception_r <= 1'b0;
          overflow_r  <= 1'b0;
          underflow_r <= 1'b0;
          inexact_r   <= 1'b0;
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result_r    <= QNAN;
            exception_r <= 1'b1;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else if (a_inf || b_inf) begin
            result_r    <= {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            exception_r <= 1'b1;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else if (a_zero || b_zero) begin
            result_r    <= {s_in, {(W-1){1'b0}}};
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            state <= MUL;
          end
        end
        MUL: begin
          if (mplier_r[0]) acc_r <= acc_r + mcand_r;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          if (cnt == '0) state <= NORM;
          else           cnt   <= cnt - CW'(1);
        end
        NORM: begin
          out_valid_r <= 1'b1;
          state       <= DONE;
          exception_r <= 1'b0;
          if (n_ovf) begin
            result_r    <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow_r  <= 1'b1;
            underflow_r <= 1'b0;
            inexact_r   <= 1'b1;
          end else if (n_unf) begin
            result_r    <= {sign_r, {(W-1){1'b0}}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b1;
            inexact_r   <= 1'b1;
          end else begin
            result_r    <= {sign_r, e_fin[EXP_W-1:0], man_sum[MAN_W-1:0]};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            inexact_r   <= guard_b | sticky_b;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.exception = exception_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
  assign bus.inexact   = inexact_r;
endmodule
